// File: rtl/jts16_dwnld_pkg.sv
// Shared types and constants for the System 16 ROM download router.
package jts16_dwnld_pkg;

   typedef enum logic [3:0] {
      MAIN, SND, PCM, GFX, OBJ, KEY, FD1089, N7751, NONE
   } region_e;

   typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_e;

   localparam logic [1:0] BA_MAIN = 2'd0;
   localparam logic [1:0] BA_SND  = 2'd1;
   localparam logic [1:0] BA_GFX  = 2'd2;
   localparam logic [1:0] BA_OBJ  = 2'd3;

   // Header layout: eight big-endian 16-bit region starts, then the game id.
   localparam int HDR_START_BYTES = 16;
   localparam int HDR_GAME_ID     = 'h18;

   typedef struct packed {
      logic [21:0] addr;
      logic [15:0] data;
      logic [1:0]  mask;
      logic [1:0]  ba;
   } word_t;

endpackage

// File: rtl/jts16_dwnld_decode.sv
// Region classifier: finds the region holding a ROM-relative byte address and
// the byte offset inside that region. Zero-length regions never match.
module jts16_dwnld_decode
   import jts16_dwnld_pkg::*;
(
   input  logic [24:0]      rel,
   input  logic [7:0][15:0] start,
   output region_e          region,
   output logic [24:0]      local_off
);

   always_comb begin
      logic [25:0] lo;
      logic [25:0] hi;
      logic        found;
      // NOTE: combinational blocks use blocking '=' and give every output a
      // default first, so no path leaves a value unassigned (no latch).
      region    = NONE;
      local_off = '0;
      found     = 1'b0;
      lo        = '0;
      hi        = '0;
      for (int i = 0; i < 8; i++) begin
         hi = {start[i], 10'b0};
         if (!found && {1'b0, rel} >= lo && {1'b0, rel} < hi) begin
            region    = region_e'(4'(i));
            local_off = 25'({1'b0, rel} - lo);
            found     = 1'b1;
         end
         lo = hi;
      end
   end

endmodule

// File: rtl/jts16_dwnld.sv
// ROM download router: parses the loader header, routes ROM bytes to SDRAM
// word writes (with a one-entry skid buffer) or to dedicated table strobes.
module jts16_dwnld
   import jts16_dwnld_pkg::*;
#(
   parameter int          HEADER     = 32,
   parameter logic [21:0] PCM_OFFSET = 22'h10_0000,
   parameter int          KEYW       = 13
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        downloading,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   output logic [21:0] prog_addr,
   output logic [15:0] prog_data,
   output logic [1:0]  prog_mask,
   output logic [1:0]  prog_ba,
   output logic        prog_we,
   input  logic        prog_rdy,
   output logic        key_we,
   output logic        fd1089_we,
   output logic        n7751_prom,
   output logic [7:0]  game_id,
   output logic        dwnld_busy
);

   logic [7:0][15:0] start;
   logic [24:0]      rel;
   logic             in_hdr;
   region_e          region;
   logic [24:0]      local_off;

   state_e state, state_nxt;
   word_t  out_q, out_nxt, skid, skid_nxt, new_word, strobe_word;
   logic   skid_valid, skid_valid_nxt, prog_we_nxt;
   logic   overflow, overflow_nxt;
   logic   wr_sdram, wr_strobe;
   logic [2:0] strobe_sel, strobe_nxt;

   assign rel    = ioctl_addr - 25'(HEADER);
   assign in_hdr = ioctl_addr < 25'(HEADER);

   jts16_dwnld_decode u_decode (
      .rel       (rel),
      .start     (start),
      .region    (region),
      .local_off (local_off)
   );

   assign wr_sdram  = downloading && ioctl_wr && !in_hdr && region inside {MAIN, SND, PCM, GFX, OBJ};
   assign wr_strobe = downloading && ioctl_wr && !in_hdr && region inside {KEY, FD1089, N7751};

   always_comb begin
      new_word      = '0;
      new_word.data = {ioctl_data, ioctl_data};
      new_word.mask = ioctl_addr[0] ? 2'b01 : 2'b10;
      new_word.addr = 22'(local_off >> 1);
      case (region)
         SND:     new_word.ba = BA_SND;
         PCM:     begin new_word.ba = BA_SND; new_word.addr = new_word.addr + PCM_OFFSET; end
         GFX:     new_word.ba = BA_GFX;
         OBJ:     new_word.ba = BA_OBJ;
         default: new_word.ba = BA_MAIN;
      endcase

      strobe_word      = '0;
      strobe_word.data = {8'h00, ioctl_data};
      strobe_sel       = 3'b000;
      case (region)
         KEY:     begin strobe_word.addr = 22'(local_off[KEYW-1:0]); strobe_sel = 3'b001; end
         FD1089:  begin strobe_word.addr = 22'(local_off[7:0]);      strobe_sel = 3'b010; end
         N7751:   begin strobe_word.addr = 22'(local_off[9:0]);      strobe_sel = 3'b100; end
         default: ;
      endcase
   end

   // Header capture; ROM data only arrives after the whole header.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<='; the header table is a
      // handful of flops, so it is cleared on reset like any other register.
      if (!rst) begin
         start   <= '0;
         game_id <= '0;
      end else if (downloading && ioctl_wr && in_hdr) begin
         if (ioctl_addr < 25'(HDR_START_BYTES)) begin
            if (ioctl_addr[0]) start[ioctl_addr[3:1]][7:0]  <= ioctl_data;
            else               start[ioctl_addr[3:1]][15:8] <= ioctl_data;
         end
         if (ioctl_addr == 25'(HDR_GAME_ID)) game_id <= ioctl_data;
      end
   end

   always_comb begin
      state_nxt      = state;
      prog_we_nxt    = prog_we;
      out_nxt        = out_q;
      skid_nxt       = skid;
      skid_valid_nxt = skid_valid;
      strobe_nxt     = 3'b000;
      overflow_nxt   = overflow;
      case (state)
         IDLE: begin
            if (wr_sdram) begin
               out_nxt     = new_word;
               prog_we_nxt = 1'b1;
               state_nxt   = WRITE;
            end else if (wr_strobe) begin
               out_nxt    = strobe_word;
               strobe_nxt = strobe_sel;
            end
         end
         WRITE, HOLD: begin
            if (prog_we && prog_rdy) begin
               prog_we_nxt = 1'b0;
               if (skid_valid) begin
                  out_nxt        = skid;
                  skid_valid_nxt = wr_sdram;
                  if (wr_sdram) skid_nxt = new_word;
               end else if (wr_sdram) begin
                  out_nxt = new_word;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               // Also re-raises prog_we after the one-cycle gap between writes.
               prog_we_nxt = 1'b1;
               if (wr_sdram) begin
                  if (skid_valid) begin
                     overflow_nxt = 1'b1;
                  end else begin
                     skid_valid_nxt = 1'b1;
                     skid_nxt       = new_word;
                  end
               end
            end
            // The output registers are owned by the SDRAM write; a table byte
            // here would corrupt it, so it is dropped like a skid overflow.
            if (wr_strobe) overflow_nxt = 1'b1;
            if (state == WRITE && !downloading && state_nxt == WRITE) state_nxt = HOLD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         prog_we    <= 1'b0;
         out_q      <= '0;
         skid       <= '0;
         skid_valid <= 1'b0;
         key_we     <= 1'b0;
         fd1089_we  <= 1'b0;
         n7751_prom <= 1'b0;
         overflow   <= 1'b0;
         dwnld_busy <= 1'b0;
      end else begin
         state      <= state_nxt;
         prog_we    <= prog_we_nxt;
         out_q      <= out_nxt;
         skid       <= skid_nxt;
         skid_valid <= skid_valid_nxt;
         key_we     <= strobe_nxt[0];
         fd1089_we  <= strobe_nxt[1];
         n7751_prom <= strobe_nxt[2];
         overflow   <= overflow_nxt;
         dwnld_busy <= downloading | (state != IDLE) | skid_valid;
      end
   end

   assign prog_addr = out_q.addr;
   assign prog_data = out_q.data;
   assign prog_mask = out_q.mask;
   assign prog_ba   = out_q.ba;

   // The loader paces its bytes so a dropped byte can never happen.
   no_overflow: assert property (@(posedge clk) disable iff (!rst) !overflow);

endmodule
